// File: rtl/data_reg_arbiter_pkg.sv
// data_reg_arbiter shared types: FSM states, release causes, stat width.
// Optional stats build: DATA_ARB_STATS_EN.
package data_arb_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    LAST,
    FORCED,
    ABANDON
  } rel_e;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/data_reg_arbiter_if.sv
// data_reg_arbiter bus: requester valid/last/data/ready, output beat/src/enable.
// slave = arbiter side, master = requesters plus downstream consumer.
interface data_reg_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         data_out;
  logic                      out_valid;
  logic                      out_ready;
  logic [SRC_W-1:0]          out_src;
  logic                      enable;

  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, data_out, out_valid, out_src, enable
  );

  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, data_out, out_valid, out_src, enable
  );

endinterface

// File: rtl/data_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: req_i request vector, ptr_i start index; found_o, idx_o first hit.
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  int j;

  // Scan offsets high to low so the nearest hit at/after ptr wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j[W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/data_reg_arbiter.sv
// data_reg_arbiter: round-robin sequencer onto one registered output beat.
// Ports: clk, rst (sync, high), bus (slave); stats ports with DATA_ARB_STATS_EN.
module data_reg_arbiter
  import data_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DATA_ARB_STATS_EN
  output logic [STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0] stat_forced,
`endif
  data_reg_arbiter_if.slave bus
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  localparam logic [SRC_W-1:0] TOP = SRC_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    grant_q, grant_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [7:0]          hold_q, hold_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ov_q, ov_d;
  logic [SRC_W-1:0]    src_q, src_d;

  logic                found;
  logic [SRC_W-1:0]    pick;
  logic                busy, rdy, acc;
  logic [NUM_REQ-1:0]  rdy_vec;
  rel_e                cause;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (pick)
  );

  assign busy = (state_q == BUSY);
  // Output slot is free when empty or draining this cycle.
  assign rdy  = !ov_q || bus.out_ready;
  assign acc  = busy && bus.req_valid[grant_q] && rdy;

  always_comb begin
    rdy_vec = '0;
    if (busy && rdy) rdy_vec[grant_q] = 1'b1;
  end

  always_comb begin
    cause = NONE;
    if (busy) begin
      unique case (1'b1)
        !bus.req_valid[grant_q]:                 cause = ABANDON;
        acc && bus.req_last[grant_q]:            cause = LAST;
        acc && !bus.req_last[grant_q]
          && hold_q == HOLD_LIM:                 cause = FORCED;
        default:                                 cause = NONE;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    data_d  = data_q;
    ov_d    = ov_q;
    src_d   = src_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          hold_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (acc) hold_d = hold_q + 8'd1;
        if (cause != NONE) begin
          state_d = IDLE;
          ptr_d   = (grant_q == TOP) ? '0 : grant_q + 1'b1;
        end
      end
    endcase
    if (acc) begin
      data_d = bus.req_data[grant_q*DATA_W +: DATA_W];
      ov_d   = 1'b1;
      src_d  = grant_q;
    end else if (bus.out_ready) begin
      ov_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      ov_q    <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      ov_q    <= ov_d;
      src_q   <= src_d;
    end
  end

  assign bus.req_ready = rdy_vec;
  assign bus.data_out  = data_q;
  assign bus.out_valid = ov_q;
  assign bus.out_src   = src_q;
  assign bus.enable    = busy;

`ifdef DATA_ARB_STATS_EN
  logic [STAT_W-1:0] grants_q, forced_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= '0;
      forced_q <= '0;
    end else begin
      if (!busy && found) grants_q <= sat_inc(grants_q);
      if (cause == FORCED) forced_q <= sat_inc(forced_q);
    end
  end

  assign stat_grants = grants_q;
  assign stat_forced = forced_q;
`endif

endmodule

// File: tb/tb_data_reg_arbiter.sv
// Directed bench for data_reg_arbiter (NUM_REQ=4, DATA_W=8, MAX_HOLD=4).
// Stats checks compile in with DATA_ARB_STATS_EN.
module tb_data_reg_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_reg_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

`ifdef DATA_ARB_STATS_EN
  logic [15:0] stat_grants, stat_forced;
`endif

  data_reg_arbiter #(
    .NUM_REQ  (4),
    .DATA_W   (8),
    .MAX_HOLD (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef DATA_ARB_STATS_EN
    .stat_grants (stat_grants),
    .stat_forced (stat_forced),
`endif
    .bus         (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] bd [4][8];
  logic       bl [4][8];
  int         n [4];
  int         p [4];
  logic [3:0] fire;

  logic [7:0] obs_d [16];
  logic [1:0] obs_s [16];
  int         nobs;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i] = 1'b0;
      bus.req_last[i] = 1'b0;
      bus.req_data[i*8 +: 8] = 8'h00;
      if (p[i] < n[i]) begin
        bus.req_valid[i] = 1'b1;
        bus.req_last[i] = bl[i][p[i]];
        bus.req_data[i*8 +: 8] = bd[i][p[i]];
      end
    end
  endtask

  task automatic clear();
    for (int i = 0; i < 4; i++) begin
      n[i] = 0;
      p[i] = 0;
    end
    drive();
  endtask

  task automatic push(int r, logic [7:0] d, logic l);
    bd[r][n[r]] = d;
    bl[r][n[r]] = l;
    n[r]++;
    drive();
  endtask

  task automatic tick();
    @(negedge clk);
    fire = bus.req_valid & bus.req_ready & {4{!rst}};
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (fire[i]) p[i]++;
    drive();
  endtask

  task automatic collect(int cyc);
    nobs = 0;
    for (int i = 0; i < 16; i++) begin
      obs_d[i] = 8'h00;
      obs_s[i] = 2'd0;
    end
    for (int c = 0; c < cyc; c++) begin
      tick();
      if (bus.out_valid && nobs < 16) begin
        obs_d[nobs] = bus.data_out;
        obs_s[nobs] = bus.out_src;
        nobs++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear();
    tick();
    tick();
    check("rst_en", bus.enable, 0);
    check("rst_ov", bus.out_valid, 0);
    check("rst_dat", bus.data_out, 0);
    check("rst_src", bus.out_src, 0);
    check("rst_rdy", bus.req_ready, 0);
`ifdef DATA_ARB_STATS_EN
    check("rst_sg", stat_grants, 0);
    check("rst_sf", stat_forced, 0);
`endif
    rst = 1'b0;
  endtask

  logic [7:0] e3d [7];
  logic [1:0] e3s [7];
  logic [7:0] e2d [5];
  logic [1:0] e2s [5];

  initial begin
    bus.out_ready = 1'b1;
    clear();

    // single packet from req 2
    do_reset();
    push(2, 8'h11, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h33, 1'b1);
    tick();
    check("t1_en", bus.enable, 1);
    check("t1_rdy", bus.req_ready, 4'b0100);
    check("t1_ov0", bus.out_valid, 0);
    tick();
    check("t1_d0", bus.data_out, 8'h11);
    check("t1_s0", bus.out_src, 2);
    check("t1_v0", bus.out_valid, 1);
    tick();
    check("t1_d1", bus.data_out, 8'h22);
    tick();
    check("t1_d2", bus.data_out, 8'h33);
    check("t1_en2", bus.enable, 0);
    tick();
    check("t1_ov3", bus.out_valid, 0);
    check("t1_en3", bus.enable, 0);

    // four 1-beat requesters, req 0 has a second packet
    do_reset();
    push(0, 8'hA0, 1'b1);
    push(0, 8'hA1, 1'b1);
    push(1, 8'hB0, 1'b1);
    push(2, 8'hC0, 1'b1);
    push(3, 8'hD0, 1'b1);
    e2d = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1};
    e2s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    nobs = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t2_en", bus.enable, k % 2);
      if (bus.out_valid && nobs < 16) begin
        obs_d[nobs] = bus.data_out;
        obs_s[nobs] = bus.out_src;
        nobs++;
      end
    end
    check("t2_cnt", nobs, 5);
    for (int i = 0; i < 5; i++) begin
      check("t2_dat", obs_d[i], e2d[i]);
      check("t2_src", obs_s[i], e2s[i]);
    end

    // forced release after MAX_HOLD beats
    do_reset();
    for (int i = 0; i < 6; i++)
      push(1, 8'h10 + 8'(i), 1'b0);
    push(3, 8'h30, 1'b1);
    e3d = '{8'h10, 8'h11, 8'h12, 8'h13,
            8'h30, 8'h14, 8'h15};
    e3s = '{2'd1, 2'd1, 2'd1, 2'd1,
            2'd3, 2'd1, 2'd1};
    collect(12);
    check("t3_cnt", nobs, 7);
    for (int i = 0; i < 7; i++) begin
      check("t3_dat", obs_d[i], e3d[i]);
      check("t3_src", obs_s[i], e3s[i]);
    end
    check("t3_en", bus.enable, 0);
`ifdef DATA_ARB_STATS_EN
    check("t3_forced", stat_forced, 1);
    check("t3_grants", stat_grants, 3);
`endif

    // backpressure holds one beat
    do_reset();
    push(0, 8'hA0, 1'b0);
    push(0, 8'hA1, 1'b0);
    push(0, 8'hA2, 1'b1);
    tick();
    tick();
    check("t4_d0", bus.data_out, 8'hA0);
    bus.out_ready = 1'b0;
    #1;
    check("t4_rdy0", bus.req_ready, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t4_ov", bus.out_valid, 1);
      check("t4_hold", bus.data_out, 8'hA0);
      check("t4_rdy", bus.req_ready, 0);
      check("t4_en", bus.enable, 1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("t4_rdy1", bus.req_ready, 4'b0001);
    tick();
    check("t4_d1", bus.data_out, 8'hA1);
    check("t4_v1", bus.out_valid, 1);
    tick();
    check("t4_d2", bus.data_out, 8'hA2);
    check("t4_en2", bus.enable, 0);
    tick();
    check("t4_ov3", bus.out_valid, 0);

    // abandon after one beat
    do_reset();
    push(0, 8'h50, 1'b0);
    push(1, 8'h60, 1'b1);
    tick();
    check("t5_rdy0", bus.req_ready, 4'b0001);
    tick();
    check("t5_d0", bus.data_out, 8'h50);
    check("t5_en1", bus.enable, 1);
    tick();
    check("t5_en2", bus.enable, 0);
    tick();
    check("t5_en3", bus.enable, 1);
    check("t5_rdy3", bus.req_ready, 4'b0010);
    tick();
    check("t5_d1", bus.data_out, 8'h60);
    check("t5_s1", bus.out_src, 1);

    // reset mid-packet clears grant, beat and pointer
    do_reset();
    push(2, 8'h70, 1'b1);
    tick();
    tick();
    push(2, 8'h71, 1'b0);
    push(2, 8'h72, 1'b0);
    push(2, 8'h73, 1'b1);
    tick();
    check("t6_rdy", bus.req_ready, 4'b0100);
    tick();
    check("t6_d", bus.data_out, 8'h71);
    rst = 1'b1;
    tick();
    check("t6_ov", bus.out_valid, 0);
    check("t6_en", bus.enable, 0);
    check("t6_rdy0", bus.req_ready, 0);
    rst = 1'b0;
    clear();
    push(0, 8'h80, 1'b1);
    push(3, 8'h83, 1'b1);
    tick();
    check("t6_ptr", bus.req_ready, 4'b0001);
    tick();
    check("t6_d1", bus.data_out, 8'h80);
    check("t6_s1", bus.out_src, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
